// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, round count, Rcon table and
// the byte/column helpers used by the round datapath.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0]  NUM_ROUNDS = 4'd10;
   localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

   // Round r (1..10) picks the r-th table byte; anything else yields zero.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      v = 8'h00;
      for (int i = 0; i < 10; i++) begin
         if (r == 4'(i + 1)) v = RCON_TABLE[79 - 8*i -: 8];
      end
      return v;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         o[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
      end
      return o;
   endfunction

   // Byte 0 sits in bits 127:120 and the state is column-major, so row r
   // of column c lives at byte index 4*c + r.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box implemented as a 256-entry lookup table.
module aes_sbox (
   input  logic [7:0] value,
   output logic [7:0] result
);

   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [10:0] idx;

   assign idx    = 11'd2047 - {value, 3'b000};
   assign result = SBOX_TABLE[idx -: 8];

endmodule

// File: rtl/aes_top.sv
// Iterative AES-128 encryptor: one full round per clock with the key
// schedule expanded on the fly alongside the data path.
module aes_top
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [127:0] plaintext,
   output logic         busy,
   output logic         done,
   output logic [127:0] ciphertext,
   output logic         fault_flag,
   output logic         power_flag
);

   state_t       state;
   logic [127:0] state_reg;
   logic [127:0] round_key;
   logic [3:0]   round_cnt;
   logic [127:0] sub_state;
   logic [127:0] shifted;
   logic [127:0] mixed;
   logic [127:0] next_key;
   logic [127:0] round_out;
   logic [31:0]  rot_word;
   logic [31:0]  sub_word;
   logic [31:0]  key_mix;
   logic [31:0]  w0, w1, w2, w3;
   logic         accept;
   logic         last_round;

   assign accept     = start && (state != RUN);
   assign last_round = (round_cnt == NUM_ROUNDS);
   assign busy       = (state == RUN);
   assign power_flag = (state == RUN);
   assign done       = (state == DONE);

   for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
      aes_sbox u_sbox (
         .value  (state_reg[8*i +: 8]),
         .result (sub_state[8*i +: 8])
      );
   end

   assign rot_word = {round_key[23:0], round_key[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sub_word
      aes_sbox u_sbox (
         .value  (rot_word[8*i +: 8]),
         .result (sub_word[8*i +: 8])
      );
   end

   // Each new key word chains off the one just produced, as in FIPS-197.
   always_comb begin
      key_mix   = sub_word ^ {rcon(round_cnt), 24'h000000};
      w0        = round_key[127:96] ^ key_mix;
      w1        = round_key[95:64] ^ w0;
      w2        = round_key[63:32] ^ w1;
      w3        = round_key[31:0] ^ w2;
      next_key  = {w0, w1, w2, w3};
      shifted   = shift_rows(sub_state);
      mixed     = last_round ? shifted : mix_columns(shifted);
      round_out = mixed ^ next_key;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         state_reg  <= '0;
         round_key  <= '0;
         round_cnt  <= '0;
         ciphertext <= '0;
         fault_flag <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  state_reg  <= plaintext ^ key;
                  round_key  <= key;
                  round_cnt  <= 4'd1;
                  fault_flag <= 1'b0;
                  state      <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (start) fault_flag <= 1'b1;
               state_reg <= round_out;
               round_key <= next_key;
               round_cnt <= round_cnt + 4'd1;
               if (last_round) begin
                  ciphertext <= round_out;
                  state      <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top: known-answer vectors from a table, a
// ciphertext scoreboard, and directed fault / reset / restart sequences.
module tb_aes_top;

   logic         clk;
   logic         rst;
   logic         start;
   logic [127:0] key;
   logic [127:0] plaintext;
   logic         busy;
   logic         done;
   logic [127:0] ciphertext;
   logic         fault_flag;
   logic         power_flag;

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   vec_t           vecs [3];
   logic [127:0]   sb_q [$];
   int             checks;
   int             errors;
   int             done_count;

   aes_top dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key        (key),
      .plaintext  (plaintext),
      .busy       (busy),
      .done       (done),
      .ciphertext (ciphertext),
      .fault_flag (fault_flag),
      .power_flag (power_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
      end
   endtask

   // Every done pulse retires the oldest expected ciphertext.
   always @(negedge clk) begin
      if (done) begin
         done_count++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: got done=1, want no pending result");
         end else begin
            check_output("ciphertext", ciphertext, sb_q.pop_front());
         end
      end
   end

   // Called at a negedge while the DUT is idle or done; returns at the
   // first negedge after the accepting edge with start released.
   task automatic apply_stimulus(input int idx, input bit expect_accept);
      key       = vecs[idx].key;
      plaintext = vecs[idx].pt;
      start     = 1'b1;
      if (expect_accept) sb_q.push_back(vecs[idx].ct);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int from, output int cycles);
      cycles = from;
      while (!done && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   int cycles;
   int snap;

   initial begin
      vecs[0] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
      vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32};
      vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f,
                  128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      checks     = 0;
      errors     = 0;
      done_count = 0;
      rst        = 1'b0;
      start      = 1'b0;
      key        = '0;
      plaintext  = '0;

      repeat (2) @(negedge clk);
      check_output("reset_busy", busy, 0);
      check_output("reset_done", done, 0);
      check_output("reset_fault", fault_flag, 0);
      check_output("reset_power", power_flag, 0);
      check_output("reset_ct", ciphertext, 0);
      rst = 1'b1;

      // Known-answer vectors, checking latency and the one-cycle done pulse.
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(i, 1'b1);
         check_output("run_busy", busy, 1);
         check_output("run_power", power_flag, 1);
         wait_done(1, cycles);
         check_output("done_latency", 128'(cycles), 128'd11);
         @(negedge clk);
         check_output("done_one_cycle", done, 0);
         check_output("idle_busy", busy, 0);
      end

      // Start during RUN: dropped, flagged, and the first result survives.
      apply_stimulus(1, 1'b1);
      repeat (2) @(negedge clk);
      apply_stimulus(2, 1'b0);
      check_output("fault_set", fault_flag, 1);
      snap = done_count;
      wait_done(4, cycles);
      check_output("fault_latency", 128'(cycles), 128'd11);
      repeat (4) @(negedge clk);
      check_output("fault_single_done", 128'(done_count - snap), 128'd1);
      check_output("fault_sticky", fault_flag, 1);
      apply_stimulus(0, 1'b1);
      check_output("fault_cleared", fault_flag, 0);
      wait_done(1, cycles);
      @(negedge clk);

      // Asynchronous reset in round 5 aborts without a done pulse.
      apply_stimulus(1, 1'b1);
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check_output("abort_busy", busy, 0);
      check_output("abort_done", done, 0);
      check_output("abort_power", power_flag, 0);
      check_output("abort_fault", fault_flag, 0);
      check_output("abort_ct", ciphertext, 0);
      sb_q.delete();
      snap = done_count;
      @(negedge clk);
      rst = 1'b1;
      repeat (15) @(negedge clk);
      check_output("abort_no_done", 128'(done_count - snap), 128'd0);
      apply_stimulus(2, 1'b1);
      wait_done(1, cycles);
      check_output("post_abort_latency", 128'(cycles), 128'd11);
      @(negedge clk);

      // Start in the DONE cycle chains a second encryption immediately.
      apply_stimulus(0, 1'b1);
      wait_done(1, cycles);
      apply_stimulus(1, 1'b1);
      check_output("chain_busy", busy, 1);
      check_output("chain_ct_held", ciphertext, vecs[0].ct);
      wait_done(1, cycles);
      check_output("chain_latency", 128'(cycles), 128'd11);
      repeat (3) @(negedge clk);

      check_output("scoreboard_empty", 128'(sb_q.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/aes_top.md
AES_TOP -- requirements
Module: aes_top

Interface
REQ-001 Parameters: none; AES-128 only, 10 rounds fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request one encryption; sampled on rising edge.
REQ-005 key  input  128  cipher key; bit 127 = FIPS-197 byte 0.
REQ-006 plaintext  input  128  input block; bit 127 = byte 0, column-major state.
REQ-007 busy  output  1  high while rounds are executing.
REQ-008 done  output  1  one-cycle pulse; ciphertext valid.
REQ-009 ciphertext  output  128  result, same byte order as plaintext.
REQ-010 fault_flag  output  1  sticky: start arrived while busy and was dropped.
REQ-011 power_flag  output  1  high while the round datapath is clock-enabled, i.e. consuming dynamic power.

Function
REQ-012 The block SHALL implement FIPS-197 AES-128 encryption: SubBytes, ShiftRows, MixColumns (omitted in round 10), AddRoundKey.
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
REQ-014 Start SHALL be accepted only in IDLE or DONE.
- On acceptance: state_reg <= plaintext XOR key; round_key <= key; round counter <= 1; fault_flag <= 0; go to RUN.
- key and plaintext are sampled only at acceptance.
REQ-015 In RUN, each cycle SHALL perform one full round (round counter 1..10).
- Next round key is expanded on the fly from the current round key with Rcon[r] = 01,02,04,08,10,20,40,80,1b,36.
- Output of round r = AddRoundKey with round key r.
REQ-016 On the round-10 edge: ciphertext <= result; go to DONE.
REQ-017 done SHALL be 1 exactly in DONE (one cycle), 11 cycles after the accepting edge; DONE -> IDLE unless start is accepted.
REQ-018 busy and power_flag SHALL be 1 exactly in RUN.
REQ-019 ciphertext SHALL hold its value until the next round-10 edge; it is not cleared by a new start.
REQ-020 start in RUN SHALL be ignored (no restart, no input resample) and SHALL set fault_flag.
- fault_flag stays set until the next accepted start or reset.
REQ-021 start held high SHALL start back-to-back encryptions: accepted in IDLE, and again in each DONE.

Reset
REQ-022 Reset SHALL take effect immediately on rst low, independent of clk.
REQ-023 Reset values: state IDLE; busy, done, fault_flag, power_flag = 0; ciphertext, state_reg, round_key, counter = 0.
REQ-024 Reset mid-RUN SHALL abort the operation; no done pulse follows.
REQ-025 The first start is accepted on the first rising edge with rst high.

Structure
REQ-026 Package aes_pkg SHALL hold:
- FSM state enum
- NUM_ROUNDS = 10
- Rcon table
- helper functions: xtime, mix_column, shift_rows
REQ-027 Sub-module aes_sbox: combinational 8-bit forward S-box (table or GF inverse + affine).
- 20 instances: 16 for SubBytes, 4 for key-schedule SubWord.
REQ-028 All datapath registers SHALL be clock-enabled only in RUN or on start acceptance.

Verification
REQ-029 Zero vector: key = 0, pt = 0 -> ct 66e94bd4ef8a2c3b884cfa59ca342b2e; done 11 cycles after the start edge.
REQ-030 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32.
REQ-031 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-032 start pulsed during RUN, with different key and pt:
- fault_flag = 1; first result unchanged; single done pulse.
- Next accepted start clears fault_flag.
REQ-033 rst low in round 5:
- All outputs immediately 0; no done pulse.
- A subsequent start gives the correct ct.
REQ-034 start asserted in the DONE cycle:
- Accepted; busy = 1 next cycle.
- Second ct correct; prior ct held until then.
